// File: rtl/cv32e40p_cg_pkg.sv
// cv32e40p_cg_pkg: shared state encoding and defaults for the clock-gate sequencer.
package cv32e40p_cg_pkg;

    typedef enum logic [1:0] {CG_RUN, CG_IDLE_WAIT, CG_GATED, CG_WAKE} cg_state_e;

    localparam int CG_IDLE_CYCLES_DEFAULT = 8;
    localparam int CG_WAKE_CYCLES_DEFAULT = 2;

    function automatic int cg_cnt_width(input int idle, input int wake);
        int m;
        m = (idle > wake) ? idle : wake;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/cv32e40p_cg_ctrl_stats.sv
// cv32e40p_cg_ctrl_stats: saturating gated-cycle and gate-event counters.
module cv32e40p_cg_ctrl_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        gated,
    input  logic        gate_event,
    output logic [31:0] gated_cycles,
    output logic [15:0] gate_events
);

    always_ff @(posedge clk) begin
        if (rst) begin
            gated_cycles <= '0;
            gate_events  <= '0;
        end else begin
            if (gated && gated_cycles != '1)
                gated_cycles <= gated_cycles + 32'd1;
            if (gate_event && gate_events != '1)
                gate_events <= gate_events + 16'd1;
        end
    end

endmodule

// File: rtl/cv32e40p_cg_ctrl.sv
// cv32e40p_cg_ctrl: idle-hysteresis / wake-latency sequencer for the core clock gate enable.
// Statistics counters are built only when CV32E40P_CG_CTRL_STATS_EN is defined.
module cv32e40p_cg_ctrl
    import cv32e40p_cg_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEFAULT,
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             force_en_i,
    input  logic             scan_cg_en_i,
    output logic             en_o,
    output logic             ready_o,
    output logic             gated_o,
    output logic [31:0]      gated_cycles_o,
    output logic [15:0]      gate_events_o
);

    localparam int CW = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CW-1:0] IDLE_LOAD = CW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] WAKE_LOAD = CW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    cg_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, ready_q, gated_q;
    logic          any_req;

    assign any_req = (|req_i) | force_en_i;
    assign en_o    = en_q | scan_cg_en_i;
    assign ready_o = ready_q;
    assign gated_o = gated_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CG_RUN: if (!any_req) begin
                state_d = (IDLE_CYCLES > 0) ? CG_IDLE_WAIT : CG_GATED;
                cnt_d   = IDLE_LOAD;
            end
            CG_IDLE_WAIT: begin
                // a request beats a simultaneous expiry
                if (any_req)
                    state_d = CG_RUN;
                else if (cnt_q == '0)
                    state_d = CG_GATED;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            CG_GATED: if (any_req) begin
                state_d = (WAKE_CYCLES > 0) ? CG_WAKE : CG_RUN;
                cnt_d   = WAKE_LOAD;
            end
            CG_WAKE: begin
                if (cnt_q == '0)
                    state_d = CG_RUN;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            default: state_d = CG_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CG_RUN;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            ready_q <= 1'b1;
            gated_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= state_d != CG_GATED;
            ready_q <= state_d == CG_RUN || state_d == CG_IDLE_WAIT;
            gated_q <= state_d == CG_GATED;
        end
    end

`ifdef CV32E40P_CG_CTRL_STATS_EN
    cv32e40p_cg_ctrl_stats u_stats (
        .clk          (clk_i),
        .rst          (rst_i),
        .gated        (state_q == CG_GATED),
        .gate_event   (state_q != CG_GATED && state_d == CG_GATED),
        .gated_cycles (gated_cycles_o),
        .gate_events  (gate_events_o)
    );
`else
    assign gated_cycles_o = '0;
    assign gate_events_o  = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_cg_ctrl.sv
// tb_cv32e40p_cg_ctrl: table-driven check of the clock-gate sequencer (IDLE=4, WAKE=2).
module tb_cv32e40p_cg_ctrl;

`ifdef CV32E40P_CG_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       frc;
        logic       scan;
        logic       en;
        logic       rdy;
        logic       g;
        int         ev;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i, force_en_i, scan_cg_en_i;
    logic [3:0]  req_i;
    logic        en_o, ready_o, gated_o;
    logic [31:0] gated_cycles_o;
    logic [15:0] gate_events_o;

    int checks = 0;
    int failures = 0;
    int exp_gc = 0;
    logic prev_g = 1'b0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    cv32e40p_cg_ctrl #(.N_REQ(4), .IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .force_en_i     (force_en_i),
        .scan_cg_en_i   (scan_cg_en_i),
        .en_o           (en_o),
        .ready_o        (ready_o),
        .gated_o        (gated_o),
        .gated_cycles_o (gated_cycles_o),
        .gate_events_o  (gate_events_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic f, input logic s,
                       input logic e, input logic y, input logic g, input int ev);
        vec_t v;
        v.rst = r; v.req = q; v.frc = f; v.scan = s;
        v.en = e; v.rdy = y; v.g = g; v.ev = ev;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t v, x;
        // reset, then idle hysteresis into GATED
        for (int i = 0; i < 3; i++) add(1, 4'b0000, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 1);
        // one-cycle wake pulse, wake completes, re-gates
        add(0, 4'b0001, 0, 0, 1, 0, 0, 1);
        add(0, 4'b0000, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 0, 0, 1, 1, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 2);
        // scan override only touches en_o
        add(0, 4'b0000, 0, 1, 1, 0, 1, 2);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 2);
        // held request wakes and stays in RUN
        add(0, 4'b0100, 0, 0, 1, 0, 0, 2);
        add(0, 4'b0100, 0, 0, 1, 0, 0, 2);
        add(0, 4'b0100, 0, 0, 1, 1, 0, 2);
        add(0, 4'b0100, 0, 0, 1, 1, 0, 2);
        // idle interrupted at T+3
        for (int i = 0; i < 3; i++) add(0, 4'b0000, 0, 0, 1, 1, 0, 2);
        for (int i = 0; i < 2; i++) add(0, 4'b0100, 0, 0, 1, 1, 0, 2);
        // request coincides with cnt==0
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 1, 1, 0, 2);
        add(0, 4'b1000, 0, 0, 1, 1, 0, 2);
        // force holds the clock, release gates five cycles later
        for (int i = 0; i < 20; i++) add(0, 4'b0000, 1, 0, 1, 1, 0, 2);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 1, 1, 0, 2);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 3);
        // reset mid-wake
        add(0, 4'b0001, 0, 0, 1, 0, 0, 3);
        add(1, 4'b0000, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 0, 0, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 1);

        rst_i = 1'b1; req_i = '0; force_en_i = 1'b0; scan_cg_en_i = 1'b0;
        #2;
        foreach (tbl[i]) begin
            v = tbl[i];
            rst_i = v.rst; req_i = v.req; force_en_i = v.frc; scan_cg_en_i = v.scan;
            sb.push_back(v);
            @(posedge clk);
            #1;
            exp_gc = v.rst ? 0 : exp_gc + int'(prev_g);
            x = sb.pop_front();
            prev_g = x.g;
            check($sformatf("en[%0d]", i), 32'(en_o), 32'(x.en));
            check($sformatf("ready[%0d]", i), 32'(ready_o), 32'(x.rdy));
            check($sformatf("gated[%0d]", i), 32'(gated_o), 32'(x.g));
            check($sformatf("events[%0d]", i), 32'(gate_events_o), STATS ? 32'(x.ev) : 32'd0);
            check($sformatf("gcycles[%0d]", i), gated_cycles_o, STATS ? 32'(exp_gc) : 32'd0);
        end
        // scan override is combinational: visible without an edge
        scan_cg_en_i = 1'b1;
        #1;
        check("scan_comb_en", 32'(en_o), 32'd1);
        check("scan_comb_gated", 32'(gated_o), 32'd1);
        check("scan_comb_ready", 32'(ready_o), 32'd0);
        scan_cg_en_i = 1'b0;
        #1;
        check("scan_release_en", 32'(en_o), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
